// File: rtl/fault_reset_sequencer.sv
// Fault reset sequencer: records the first fault, then drives a drained,
// fixed-width system reset pulse; also takes software reset requests.
//
// Ports:
//   clk, rst            clock, async active-high power-on reset
//   fault, fault_cause  fault level and cause code from the fault encoder
//   fault_addr          faulting address / PC from the fault encoder
//   sw_rst_req          single-cycle software reset request
//   clr                 clears the sticky record and the reset count
//   rd_en, rd_addr      read strobe; 0 status, 1 address, 2 count, 3 rsvd
//   rd_data             registered read data
//   sys_rst             system reset pulse to core, buses, peripherals
//   rec_valid/cause/addr sticky first-fault record
//   fault_cnt           saturating count of sequenced resets

`ifndef XLEN
`define XLEN 32
`endif

module fault_reset_sequencer #(
    parameter int         DRAIN_CYCLES = 4,
    parameter int         RST_CYCLES   = 8,
    parameter logic [7:0] SW_CAUSE     = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fault,
    input  logic [7:0]       fault_cause,
    input  logic [`XLEN-1:0] fault_addr,
    input  logic             sw_rst_req,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [1:0]       rd_addr,
    output logic [`XLEN-1:0] rd_data,
    output logic             sys_rst,
    output logic             rec_valid,
    output logic [7:0]       rec_cause,
    output logic [`XLEN-1:0] rec_addr,
    output logic [7:0]       fault_cnt
);

    localparam int         XL         = `XLEN;
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] RST_LOAD   = 8'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_ASSERT,
        S_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    cnt, cnt_nx;
    logic          trig_fault, trig_sw, trigger;
    logic [XL-1:0] rd_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_ASSERT;
            cnt     <= RST_LOAD;
            sys_rst <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            // registered so the reset line is glitch-free
            sys_rst <= (state_nx == S_ASSERT);
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        trig_fault = 1'b0;
        trig_sw    = 1'b0;
        unique case (state)
            S_IDLE: begin
                // fault has priority; a coincident sw request is dropped
                if (fault) begin
                    trig_fault = 1'b1;
                end else if (sw_rst_req) begin
                    trig_sw = 1'b1;
                end
                if (fault || sw_rst_req) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (cnt == 8'd0) begin
                    state_nx = S_ASSERT;
                    cnt_nx   = RST_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_ASSERT: begin
                if (cnt == 8'd0) begin
                    state_nx = S_RELEASE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            // one dead cycle so a stale fault level cannot retrigger
            S_RELEASE: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    assign trigger = trig_fault | trig_sw;

    always_comb begin
        rd_mux = '0;
        unique case (rd_addr)
            2'd0:    rd_mux = {{(XL-9){1'b0}}, rec_valid, rec_cause};
            2'd1:    rd_mux = rec_addr;
            2'd2:    rd_mux = {{(XL-8){1'b0}}, fault_cnt};
            default: rd_mux = '0;
        endcase
    end

    // Sticky record: only power-on reset and clr touch it, never sys_rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_valid <= 1'b0;
            rec_cause <= 8'd0;
            rec_addr  <= '0;
            fault_cnt <= 8'd0;
            rd_data   <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= rd_mux;
            end
            if (trigger) begin
                // a coincident clr restarts the count at this trigger
                if (clr) begin
                    fault_cnt <= 8'd1;
                end else if (fault_cnt != 8'hFF) begin
                    fault_cnt <= fault_cnt + 8'd1;
                end
                if (!rec_valid || clr) begin
                    rec_valid <= 1'b1;
                    rec_cause <= trig_fault ? fault_cause : SW_CAUSE;
                    rec_addr  <= trig_fault ? fault_addr : '0;
                end
            end else if (clr) begin
                rec_valid <= 1'b0;
                rec_cause <= 8'd0;
                rec_addr  <= '0;
                fault_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_fault_reset_sequencer.sv
// Directed bench for fault_reset_sequencer: read-port vector table plus
// hand-written reset sequences (DRAIN_CYCLES = 4, RST_CYCLES = 8).

module tb_fault_reset_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fault = 1'b0;
    logic [7:0]  fault_cause = 8'd0;
    logic [31:0] fault_addr = 32'd0;
    logic        sw_rst_req = 1'b0;
    logic        clr = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    logic [31:0] rd_data;
    logic        sys_rst;
    logic        rec_valid;
    logic [7:0]  rec_cause;
    logic [31:0] rec_addr;
    logic [7:0]  fault_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fault_reset_sequencer #(
        .DRAIN_CYCLES(4),
        .RST_CYCLES  (8),
        .SW_CAUSE    (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fault      (fault),
        .fault_cause(fault_cause),
        .fault_addr (fault_addr),
        .sw_rst_req (sw_rst_req),
        .clr        (clr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .sys_rst    (sys_rst),
        .rec_valid  (rec_valid),
        .rec_cause  (rec_cause),
        .rec_addr   (rec_addr),
        .fault_cnt  (fault_cnt)
    );

    typedef struct {
        string       name;
        logic        en;
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reads(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_en   = vecs[i].en;
            rd_addr = vecs[i].addr;
            tick();
            check(vecs[i].name, rd_data, vecs[i].exp);
        end
        rd_en = 1'b0;
    endtask

    // Trigger in IDLE, then measure drain latency and pulse width.
    task automatic run_seq(input logic f, input logic sw,
                           input logic [7:0] c, input logic [31:0] a,
                           input bit hold, input string name);
        int n;
        fault       = f;
        sw_rst_req  = sw;
        fault_cause = c;
        fault_addr  = a;
        tick();
        if (!hold) fault = 1'b0;
        sw_rst_req = 1'b0;
        clr        = 1'b0;
        rd_en      = 1'b0;
        n = 0;
        while (!sys_rst && n < 50) begin
            tick();
            n++;
        end
        check({name, " drain"}, n, 4);
        n = 0;
        while (sys_rst && n < 50) begin
            tick();
            n++;
        end
        check({name, " width"}, n, 8);
        tick();
        fault = 1'b0;
    endtask

    initial begin
        int n;

        vecs[0] = '{"rd status", 1'b1, 2'd0, 32'h0000_0102};
        vecs[1] = '{"rd rsvd",   1'b1, 2'd3, 32'h0000_0000};
        vecs[2] = '{"rd addr",   1'b1, 2'd1, 32'h0000_1234};
        vecs[3] = '{"rd hold",   1'b0, 2'd2, 32'h0000_1234};
        vecs[4] = '{"rd cnt1",   1'b1, 2'd2, 32'h0000_0001};
        vecs[5] = '{"rd cnt2",   1'b1, 2'd2, 32'h0000_0002};
        vecs[6] = '{"rd addr2",  1'b1, 2'd1, 32'h0000_1234};
        vecs[7] = '{"rd stat2",  1'b1, 2'd0, 32'h0000_0102};

        // power-on
        tick();
        check("por sys_rst", 32'(sys_rst), 1);
        check("por valid", 32'(rec_valid), 0);
        check("por cnt", 32'(fault_cnt), 0);
        check("por rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        n = 0;
        while (sys_rst && n < 50) begin
            tick();
            n++;
        end
        check("por width", n, 8);
        tick();
        check("por cnt after", 32'(fault_cnt), 0);
        check("por valid after", 32'(rec_valid), 0);

        // first fault
        run_seq(1'b1, 1'b0, 8'h02, 32'h0000_1234, 1'b0, "f1");
        check("f1 valid", 32'(rec_valid), 1);
        check("f1 cause", 32'(rec_cause), 32'h02);
        check("f1 addr", rec_addr, 32'h0000_1234);
        check("f1 cnt", 32'(fault_cnt), 1);
        apply_reads(0, 4);

        // second fault: first-fault-wins
        run_seq(1'b1, 1'b0, 8'h03, 32'h0000_5678, 1'b0, "f2");
        check("f2 cause", 32'(rec_cause), 32'h02);
        check("f2 addr", rec_addr, 32'h0000_1234);
        apply_reads(5, 7);

        // clr alone
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr valid", 32'(rec_valid), 0);
        check("clr cause", 32'(rec_cause), 0);
        check("clr addr", rec_addr, 0);
        check("clr cnt", 32'(fault_cnt), 0);

        // fault and sw together
        run_seq(1'b1, 1'b1, 8'h05, 32'h0000_AAAA, 1'b0, "both");
        tick();
        tick();
        check("both no 2nd", 32'(sys_rst), 0);
        check("both cause", 32'(rec_cause), 32'h05);
        check("both addr", rec_addr, 32'h0000_AAAA);
        check("both cnt", 32'(fault_cnt), 1);

        // sw alone
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run_seq(1'b0, 1'b1, 8'h44, 32'h0000_9999, 1'b0, "sw");
        check("sw cause", 32'(rec_cause), 32'hFF);
        check("sw addr", rec_addr, 0);
        check("sw cnt", 32'(fault_cnt), 1);

        // sw pulses during DRAIN and ASSERT are ignored
        fault       = 1'b1;
        fault_cause = 8'h07;
        tick();
        fault      = 1'b0;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        n = 1;
        while (!sys_rst && n < 50) begin
            tick();
            n++;
        end
        check("ign drain", n, 4);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        n = 1;
        while (sys_rst && n < 50) begin
            tick();
            n++;
        end
        check("ign width", n, 8);
        tick();
        tick();
        tick();
        check("ign idle", 32'(sys_rst), 0);
        check("ign cnt", 32'(fault_cnt), 2);
        check("ign cause", 32'(rec_cause), 32'hFF);

        // fault held through ASSERT: RELEASE blocks a retrigger
        run_seq(1'b1, 1'b0, 8'h09, 32'h0, 1'b1, "hold");
        tick();
        tick();
        check("hold idle", 32'(sys_rst), 0);
        check("hold cnt", 32'(fault_cnt), 3);

        // clr with trigger, read in the same cycle sees pre-capture
        clr     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 2'd0;
        run_seq(1'b1, 1'b0, 8'h11, 32'h0000_2222, 1'b0, "clrtrig");
        check("clrtrig rd", rd_data, 32'h0000_01FF);
        check("clrtrig valid", 32'(rec_valid), 1);
        check("clrtrig cause", 32'(rec_cause), 32'h11);
        check("clrtrig addr", rec_addr, 32'h0000_2222);
        check("clrtrig cnt", 32'(fault_cnt), 1);

        // saturation
        for (int i = 0; i < 254; i++) begin
            run_seq(1'b0, 1'b1, 8'h0, 32'h0, 1'b0, "sat");
        end
        check("sat 255", 32'(fault_cnt), 255);
        for (int i = 0; i < 2; i++) begin
            run_seq(1'b0, 1'b1, 8'h0, 32'h0, 1'b0, "sat+");
        end
        check("sat hold", 32'(fault_cnt), 255);

        // rst mid-DRAIN
        fault       = 1'b1;
        fault_cause = 8'h33;
        tick();
        fault = 1'b0;
        tick();
        check("mid pre sys_rst", 32'(sys_rst), 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid sys_rst", 32'(sys_rst), 1);
        check("mid valid", 32'(rec_valid), 0);
        check("mid cause", 32'(rec_cause), 0);
        check("mid addr", rec_addr, 0);
        check("mid cnt", 32'(fault_cnt), 0);
        check("mid rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        n = 0;
        while (sys_rst && n < 50) begin
            tick();
            n++;
        end
        check("mid width", n, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fault_reset_sequencer.md
Name: fault_reset_sequencer

Overview:
- Sits directly downstream of the fault encoder and consumes its registered `fault` / `fault_cause` / `fault_addr` outputs.
- Records the first fault into sticky status registers; these survive the system reset they trigger and are cleared only by power-on reset or a software clear.
- Sequences the system reset: drain holdoff, then a fixed-width `sys_rst` pulse to core, buses, peripherals and the fault encoder.
- Also accepts a software reset request; exposes the record through a small registered read port.

Parameters:
- DRAIN_CYCLES, 4, cycles between the trigger and `sys_rst` assertion (lets outstanding bus beats settle); legal range 1..255.
- RST_CYCLES, 8, width of the `sys_rst` pulse in cycles; legal range 1..255.
- SW_CAUSE, 8'hFF, cause code recorded for a software reset; must differ from every `RST_FAULT_*` code.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high power-on reset.
- fault  in  1  level from the fault encoder; high = a fault is latched.
- fault_cause  in  8  fault encoder cause code (`RST_FAULT_*`).
- fault_addr  in  `XLEN  fault encoder faulting address / PC.
- sw_rst_req  in  1  single-cycle software reset request.
- clr  in  1  single-cycle clear of the sticky record and the count.
- rd_en  in  1  register read strobe.
- rd_addr  in  2  0 = status, 1 = address, 2 = count, 3 = reserved.
- rd_data  out  `XLEN  registered read data.
- sys_rst  out  1  active-high system reset to the core, buses, peripherals and fault encoder.
- rec_valid  out  1  sticky record present.
- rec_cause  out  8  recorded cause.
- rec_addr  out  `XLEN  recorded address (0 for a software reset).
- fault_cnt  out  8  count of sequenced resets, saturating.

Behaviour:
- Reset values (async, while `rst` = 1):
  - state = ASSERT, with the cycle counter loaded to RST_CYCLES-1.
  - `sys_rst` = 1.
  - `rec_valid` = 0, `rec_cause` = 0, `rec_addr` = 0, `fault_cnt` = 0, `rd_data` = 0.
- Power-on: after `rst` falls, `sys_rst` stays high exactly RST_CYCLES more rising edges, then releases. A power-on pulse does not increment `fault_cnt`.
- IDLE (`sys_rst` = 0). Triggers, evaluated each cycle:
  - `fault` = 1: the trigger is the fault.
  - else `sw_rst_req` = 1: the trigger is the software request.
  - Simultaneous `fault` and `sw_rst_req`: the fault wins and the software request is dropped.
- On a trigger, at the same edge:
  - Go to DRAIN with the counter = DRAIN_CYCLES-1.
  - `fault_cnt` += 1, saturating at 255.
  - If `rec_valid` = 0: capture `rec_cause` = `fault_cause` (or SW_CAUSE), `rec_addr` = `fault_addr` (or 0), and set `rec_valid` = 1.
  - If `rec_valid` = 1: no overwrite (first-fault-wins).
- DRAIN: the counter decrements each cycle. At 0, go to ASSERT with the counter = RST_CYCLES-1. `sys_rst` rises on that edge.
- ASSERT: `sys_rst` = 1; the counter decrements. At 0, go to RELEASE and drop `sys_rst`.
- RELEASE (1 cycle): return to IDLE. This blocks immediate retrigger on a stale `fault` that the encoder (cleared by `sys_rst`) is still dropping.
- Latency:
  - Trigger edge to first `sys_rst` = 1: DRAIN_CYCLES cycles.
  - `sys_rst` high: RST_CYCLES cycles.
- Triggers seen in DRAIN, ASSERT or RELEASE are ignored: no count, no capture.
- `clr`: at the next edge, `rec_valid` = 0, `rec_cause` = 0, `rec_addr` = 0, `fault_cnt` = 0, in any state.
  - `clr` in the same cycle as an IDLE trigger: the capture and increment win; the record and count reflect the new trigger only (count = 1).
- Read port:
  - When `rd_en` = 1, `rd_data` updates at the next edge:
    - addr 0: {zeros, `rec_valid`, `rec_cause`[7:0]} — `rec_valid` at bit 8.
    - addr 1: `rec_addr`.
    - addr 2: zero-extended `fault_cnt`.
    - addr 3: 0.
  - When `rd_en` = 0, `rd_data` holds its value.
  - A read in the same cycle as a capture returns the pre-capture value.
- The sticky record and `fault_cnt` are not affected by `sys_rst`, only by `rst` and `clr`.
- `rst` asserted mid-sequence: immediate return to the reset values. A pending record is lost only because `rst` clears it.

Test Plan:
- Power-on (DRAIN_CYCLES = 4, RST_CYCLES = 8): release `rst` → `sys_rst` high for 8 more edges, then 0; `fault_cnt` = 0, `rec_valid` = 0.
- `fault` = 1, cause 8'h02, addr 32'h0000_1234 in IDLE → `sys_rst` rises 4 cycles later and is high for 8 cycles; `rec_cause` = 02, `rec_addr` = 0000_1234, `rec_valid` = 1, `fault_cnt` = 1; a read of addr 0 returns 32'h0000_0102.
- Second fault (cause 03, addr 32'h0000_5678) after the first sequence → `fault_cnt` = 2, record unchanged (02 / 0000_1234).
- `fault` and `sw_rst_req` together → cause = the fault code, a single sequence, `fault_cnt` += 1; `sw_rst_req` alone → `rec_cause` = FF, `rec_addr` = 0.
- `sw_rst_req` pulsed during DRAIN and during ASSERT → no extra sequence, count unchanged; `fault` held high through the end of ASSERT → exactly one sequence thanks to RELEASE.
- `clr` together with a trigger → `rec_valid` = 1 with the new cause, `fault_cnt` = 1.
- 256 triggered sequences → `fault_cnt` stays 255.
- `rst` pulsed mid-DRAIN → all outputs at reset values and `sys_rst` = 1 immediately.
